// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Conditions a raw, low-active, bouncy push-button pin into clean events.
// The pin is synchronised, then a four-state FSM requires DebounceCycles
// consecutive identical samples before committing a press or a release. A
// hold timer running while the button is down produces a long-press event.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   btnx          raw button pin, low = pressed, asynchronous to clk
//   btn_level     debounced level, 1 = pressed
//   press_tick    one-cycle pulse when a press commits
//   release_tick  one-cycle pulse when a release commits
//   long_tick     one-cycle pulse when the hold reaches LongPressCycles
//   long_held     high from long_tick until the release commits
//   press_count   committed presses, wrapping modulo 2^CountWidth
//
// All outputs come straight from flops; btnx has no combinational path out.
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int SyncStages      = 2,
    parameter int DebounceCycles  = 240000,
    parameter int LongPressCycles = 24000000,
    parameter int CountWidth      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btnx,
    output logic                  btn_level,
    output logic                  press_tick,
    output logic                  release_tick,
    output logic                  long_tick,
    output logic                  long_held,
    output logic [CountWidth-1:0] press_count
);

    localparam int MaxCycles = (LongPressCycles > DebounceCycles) ? LongPressCycles
                                                                  : DebounceCycles;
    localparam int CntW      = $clog2(MaxCycles + 1);

    // deb_cnt counts the samples after the one that entered a *_DB state,
    // so the commit happens when it reaches DebounceCycles-2.
    localparam logic [CntW-1:0] DebLast  = CntW'((DebounceCycles >= 2) ? DebounceCycles - 2 : 0);
    localparam logic [CntW-1:0] LongLast = CntW'((LongPressCycles >= 1) ? LongPressCycles - 1 : 0);
    localparam logic [CntW-1:0] LongMax  = CntW'(LongPressCycles);
    localparam bit              DebOne   = (DebounceCycles == 1);
    localparam bit              LongEn   = (LongPressCycles != 0);

    // Parameter sanity, reported at elaboration.
    if (SyncStages < 2) begin : g_bad_sync
        $error("button_debouncer: SyncStages must be >= 2");
    end
    if (DebounceCycles < 1) begin : g_bad_deb
        $error("button_debouncer: DebounceCycles must be >= 1");
    end
    if (LongPressCycles != 0 && LongPressCycles <= DebounceCycles) begin : g_bad_long
        $error("button_debouncer: LongPressCycles must be 0 or > DebounceCycles");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    logic [SyncStages-1:0] r_sync;
    state_t                r_state;
    logic [CntW-1:0]       r_deb_cnt;
    logic [CntW-1:0]       r_hold_cnt;

    logic w_s;
    logic w_in_hold;
    logic w_deb_done;
    logic w_press_commit;
    logic w_rel_commit;
    logic w_long_hit;

    assign w_s = r_sync[SyncStages-1];

    // Presetting to 1 makes the chain look "released" straight out of reset,
    // so a button still held during reset is reported as a fresh press.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], btnx};
        end
    end

    // NOTE: every always_comb output is assigned on every path, so no latch
    // can be inferred.
    always_comb begin
        w_in_hold      = (r_state == HELD) || (r_state == RELEASE_DB);
        w_deb_done     = (r_deb_cnt == DebLast);
        w_press_commit = !w_s && (((r_state == PRESS_DB) && w_deb_done) ||
                                  (DebOne && (r_state == IDLE)));
        w_rel_commit   =  w_s && (((r_state == RELEASE_DB) && w_deb_done) ||
                                  (DebOne && (r_state == HELD)));
        // A release committing on the threshold edge suppresses the long event.
        w_long_hit     = LongEn && w_in_hold && (r_hold_cnt == LongLast) && !w_rel_commit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_deb_cnt    <= '0;
            r_hold_cnt   <= '0;
            btn_level    <= 1'b0;
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            long_tick    <= 1'b0;
            long_held    <= 1'b0;
            press_count  <= '0;
        end else begin
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            long_tick    <= 1'b0;

            // Hold timer keeps running through release bounces and saturates,
            // which is what limits long_tick to once per press.
            if (LongEn && w_in_hold && (r_hold_cnt != LongMax)) begin
                r_hold_cnt <= r_hold_cnt + CntW'(1);
            end
            if (w_long_hit) begin
                long_tick <= 1'b1;
                long_held <= 1'b1;
            end

            if (w_press_commit) begin
                r_state     <= HELD;
                btn_level   <= 1'b1;
                press_tick  <= 1'b1;
                press_count <= press_count + CountWidth'(1);
                r_hold_cnt  <= '0;
            end else if (w_rel_commit) begin
                r_state      <= IDLE;
                btn_level    <= 1'b0;
                release_tick <= 1'b1;
                long_held    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!w_s) begin
                            r_state   <= PRESS_DB;
                            r_deb_cnt <= '0;
                        end
                    end
                    PRESS_DB: begin
                        if (w_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + CntW'(1);
                        end
                    end
                    HELD: begin
                        if (w_s) begin
                            r_state   <= RELEASE_DB;
                            r_deb_cnt <= '0;
                        end
                    end
                    RELEASE_DB: begin
                        if (!w_s) begin
                            r_state <= HELD;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + CntW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
